// File: rtl/bank_mix_datapath.sv
// Looper data path: stages ADC samples onto the RAM write bus, latches per-bank read data,
// and produces one saturated mix of the playing banks (plus optional live input) for the DAC.
module bank_mix_datapath #(
    parameter int DW    = 16,
    parameter int NBANK = 8
) (
    input  logic          clk_100MHz,
    input  logic          rst,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_in_valid,
    input  logic [7:0]    playing,
    input  logic [7:0]    recording,
    input  logic [2:0]    mem_bank,
    input  logic          get_data,
    input  logic          data_ready,
    input  logic          mix_data,
    input  logic          write_zero,
    input  logic          ram_wen_n,
    input  logic [DW-1:0] ram_dq_in,
    input  logic          monitor_en,
    input  logic          flag_clr,
    output logic [DW-1:0] ram_dq_out,
    output logic          ram_dq_oe,
    output logic [DW-1:0] mix_out,
    output logic          mix_valid,
    output logic          busy,
    output logic          clip,
    output logic          overrun
);

    // All control inputs are single-cycle strobes from the controller; there is no
    // backpressure, so a mix_data that lands while busy is dropped and flagged.
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_MON,
        S_SAT
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [2:0]           idx;
    logic signed [DW+3:0] acc;
    logic [7:0]           play_snap;
    logic                 mon_snap;
    logic [DW-1:0]        in_hold;
    logic [DW-1:0]        wr_data;
    logic [DW-1:0]        bank_reg [NBANK];
    logic [DW-1:0]        sat_val;
    logic                 sat_hit;

    localparam logic signed [DW+3:0] ACC_MAX = {5'b00000, {(DW-1){1'b1}}};
    localparam logic signed [DW+3:0] ACC_MIN = {5'b11111, {(DW-1){1'b0}}};

    function automatic logic signed [DW+3:0] sext(input logic [DW-1:0] v);
        return {{4{v[DW-1]}}, v};
    endfunction

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (mix_data) state_nxt = S_ACC;
            S_ACC:   if (idx == 3'd7) state_nxt = S_MON;
            S_MON:   state_nxt = S_SAT;
            S_SAT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        sat_val = acc[DW-1:0];
        sat_hit = 1'b0;
        if (acc > ACC_MAX) begin
            sat_val = {1'b0, {(DW-1){1'b1}}};
            sat_hit = 1'b1;
        end else if (acc < ACC_MIN) begin
            sat_val = {1'b1, {(DW-1){1'b0}}};
            sat_hit = 1'b1;
        end
    end

    // Mix sequencing: one bank per cycle, then the monitor term, then clamp.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            idx       <= '0;
            play_snap <= '0;
            mon_snap  <= 1'b0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mix_data) begin
                        acc       <= '0;
                        idx       <= '0;
                        play_snap <= playing;
                        mon_snap  <= monitor_en;
                    end
                end
                S_ACC: begin
                    acc <= acc + (play_snap[idx] ? sext(bank_reg[idx]) : '0);
                    idx <= idx + 3'd1;
                end
                S_MON: acc <= acc + (mon_snap ? sext(in_hold) : '0);
                S_SAT: begin
                    mix_out   <= sat_val;
                    mix_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as flag_clr wins.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            clip    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (state == S_SAT && sat_hit) clip <= 1'b1;
            else if (flag_clr)             clip <= 1'b0;
            if (mix_data && state != S_IDLE) overrun <= 1'b1;
            else if (flag_clr)               overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            in_hold    <= '0;
            wr_data    <= '0;
            ram_dq_out <= '0;
            ram_dq_oe  <= 1'b0;
        end else begin
            if (sample_in_valid) in_hold <= sample_in;
            if (get_data)        wr_data <= in_hold;
            ram_dq_out <= write_zero ? '0 : wr_data;
            // Erase drives the bus for every bank; otherwise only record-armed banks.
            ram_dq_oe  <= (write_zero || recording[mem_bank]) ? ~ram_wen_n : 1'b0;
        end
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBANK; i++) bank_reg[i] <= '0;
        end else if (data_ready && !write_zero) begin
            bank_reg[mem_bank] <= (playing[mem_bank] && !recording[mem_bank]) ? ram_dq_in : '0;
        end
    end

endmodule

// File: tb/tb_bank_mix_datapath.sv
// Directed bench for bank_mix_datapath: capture/write path, bank latching, mix, saturation, flags, reset abort.
module tb_bank_mix_datapath;

    logic        clk_100MHz = 1'b0;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_in_valid;
    logic [7:0]  playing;
    logic [7:0]  recording;
    logic [2:0]  mem_bank;
    logic        get_data;
    logic        data_ready;
    logic        mix_data;
    logic        write_zero;
    logic        ram_wen_n;
    logic [15:0] ram_dq_in;
    logic        monitor_en;
    logic        flag_clr;
    logic [15:0] ram_dq_out;
    logic        ram_dq_oe;
    logic [15:0] mix_out;
    logic        mix_valid;
    logic        busy;
    logic        clip;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    bank_mix_datapath dut (
        .clk_100MHz      (clk_100MHz),
        .rst             (rst),
        .sample_in       (sample_in),
        .sample_in_valid (sample_in_valid),
        .playing         (playing),
        .recording       (recording),
        .mem_bank        (mem_bank),
        .get_data        (get_data),
        .data_ready      (data_ready),
        .mix_data        (mix_data),
        .write_zero      (write_zero),
        .ram_wen_n       (ram_wen_n),
        .ram_dq_in       (ram_dq_in),
        .monitor_en      (monitor_en),
        .flag_clr        (flag_clr),
        .ram_dq_out      (ram_dq_out),
        .ram_dq_oe       (ram_dq_oe),
        .mix_out         (mix_out),
        .mix_valid       (mix_valid),
        .busy            (busy),
        .clip            (clip),
        .overrun         (overrun)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_bank(input logic [2:0] b, input logic [15:0] d);
        mem_bank   = b;
        ram_dq_in  = d;
        data_ready = 1'b1;
        @(negedge clk_100MHz);
        data_ready = 1'b0;
    endtask

    task automatic pulse_flag_clr();
        flag_clr = 1'b1;
        @(negedge clk_100MHz);
        flag_clr = 1'b0;
    endtask

    // mix_data sampled at edge N; mix_valid must be seen on the 11th negedge after driving it.
    task automatic do_mix(input string tag, input logic [15:0] exp_out, input logic exp_clip);
        int lat;
        lat      = 0;
        mix_data = 1'b1;
        @(negedge clk_100MHz);
        mix_data = 1'b0;
        check({tag, "_busy"}, busy, 1);
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk_100MHz);
            if (mix_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, 11);
        check({tag, "_mix_out"}, mix_out, exp_out);
        check({tag, "_clip"}, clip, exp_clip);
        check({tag, "_idle"}, busy, 0);
        @(negedge clk_100MHz);
        check({tag, "_valid_pulse"}, mix_valid, 0);
    endtask

    initial begin
        int nvalid;
        rst             = 1'b1;
        sample_in       = '0;
        sample_in_valid = 1'b0;
        playing         = '0;
        recording       = '0;
        mem_bank        = '0;
        get_data        = 1'b0;
        data_ready      = 1'b0;
        mix_data        = 1'b0;
        write_zero      = 1'b0;
        ram_wen_n       = 1'b1;
        ram_dq_in       = '0;
        monitor_en      = 1'b0;
        flag_clr        = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_100MHz);
        check("rst_dq_out", ram_dq_out, 0);
        check("rst_dq_oe", ram_dq_oe, 0);
        check("rst_mix_out", mix_out, 0);
        check("rst_mix_valid", mix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_clip", clip, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        @(negedge clk_100MHz);

        // 1: two playing banks, no saturation
        playing = 8'b0000_1001;
        load_bank(3'd0, 16'h1000);
        load_bank(3'd3, 16'h0200);
        do_mix("t1", 16'h1200, 1'b0);

        // 2: positive and negative saturation, flag clear
        playing = 8'h0F;
        for (int b = 0; b < 4; b++) load_bank(b[2:0], 16'h7000);
        do_mix("t2_pos", 16'h7FFF, 1'b1);
        pulse_flag_clr();
        check("t2_clip_clr", clip, 0);
        for (int b = 0; b < 4; b++) load_bank(b[2:0], 16'h9000);
        do_mix("t2_neg", 16'h8000, 1'b1);
        pulse_flag_clr();
        check("t2_clip_clr2", clip, 0);

        // 3: write path and recording bank latch-to-zero
        sample_in       = 16'h1234;
        sample_in_valid = 1'b1;
        @(negedge clk_100MHz);
        sample_in_valid = 1'b0;
        playing   = 8'h04;
        recording = 8'h04;
        mem_bank  = 3'd2;
        ram_wen_n = 1'b0;
        get_data  = 1'b1;
        @(negedge clk_100MHz);
        get_data = 1'b0;
        @(negedge clk_100MHz);
        check("t3_dq_out", ram_dq_out, 16'h1234);
        check("t3_dq_oe", ram_dq_oe, 1);
        sample_in       = 16'h5555;
        sample_in_valid = 1'b1;
        get_data        = 1'b1;
        @(negedge clk_100MHz);
        sample_in_valid = 1'b0;
        get_data        = 1'b0;
        @(negedge clk_100MHz);
        check("t3_old_hold", ram_dq_out, 16'h1234);
        get_data = 1'b1;
        @(negedge clk_100MHz);
        get_data = 1'b0;
        @(negedge clk_100MHz);
        check("t3_new_hold", ram_dq_out, 16'h5555);
        mem_bank = 3'd5;
        @(negedge clk_100MHz);
        check("t3_oe_gated", ram_dq_oe, 0);
        ram_wen_n = 1'b1;
        load_bank(3'd2, 16'h4444);
        do_mix("t3", 16'h0000, 1'b0);

        // 4: erase forces zero data, drives bus, ignores data_ready
        recording  = 8'h00;
        write_zero = 1'b1;
        ram_wen_n  = 1'b0;
        mem_bank   = 3'd5;
        @(negedge clk_100MHz);
        check("t4_dq_out", ram_dq_out, 0);
        check("t4_dq_oe", ram_dq_oe, 1);
        playing = 8'h48;
        load_bank(3'd6, 16'h0777);
        write_zero = 1'b0;
        ram_wen_n  = 1'b1;
        @(negedge clk_100MHz);
        check("t4_dq_restore", ram_dq_out, 16'h5555);
        check("t4_oe_off", ram_dq_oe, 0);
        do_mix("t4", 16'h9000, 1'b0);

        // 5: monitor term and overrun
        sample_in       = 16'hFFFF;
        sample_in_valid = 1'b1;
        @(negedge clk_100MHz);
        sample_in_valid = 1'b0;
        playing = 8'h02;
        load_bank(3'd1, 16'h0001);
        do_mix("t5_nomon", 16'h0001, 1'b0);
        monitor_en = 1'b1;
        mix_data   = 1'b1;
        @(negedge clk_100MHz);
        mix_data = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        check("t5_no_overrun_yet", overrun, 0);
        mix_data = 1'b1;
        @(negedge clk_100MHz);
        mix_data = 1'b0;
        check("t5_overrun", overrun, 1);
        nvalid = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_100MHz);
            if (mix_valid) nvalid++;
        end
        check("t5_single_valid", nvalid, 1);
        check("t5_mix_out", mix_out, 16'h0000);

        // 6: asynchronous reset mid-mix
        monitor_en = 1'b0;
        do_mix("t6_pre", 16'h0001, 1'b0);
        recording = 8'h02;
        mem_bank  = 3'd1;
        ram_wen_n = 1'b0;
        @(negedge clk_100MHz);
        check("t6_pre_oe", ram_dq_oe, 1);
        mix_data = 1'b1;
        @(negedge clk_100MHz);
        mix_data = 1'b0;
        repeat (4) @(negedge clk_100MHz);
        check("t6_busy_mid", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_busy", busy, 0);
        check("t6_mix_valid", mix_valid, 0);
        check("t6_mix_out", mix_out, 0);
        check("t6_dq_out", ram_dq_out, 0);
        check("t6_dq_oe", ram_dq_oe, 0);
        check("t6_clip", clip, 0);
        check("t6_overrun", overrun, 0);
        @(negedge clk_100MHz);
        ram_wen_n = 1'b1;
        recording = 8'h00;
        rst       = 1'b0;
        nvalid    = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk_100MHz);
            if (mix_valid) nvalid++;
        end
        check("t6_no_valid", nvalid, 0);
        check("t6_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
